// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: ID/EX/WB status from the pipeline, stall/flush controls back.
interface pipeline_hazard_controller_if;
  logic        id_valid;
  logic        id_regWrite;
  logic        id_jumpMem;
  logic        id_useRs1;
  logic        id_useRs2;
  logic [5:0]  id_rs1;
  logic [5:0]  id_rs2;
  logic [5:0]  id_rd;
  logic        ex_redirect;
  logic        wb_redirect;
  logic        wb_regWrite;
  logic [5:0]  wb_rd;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        issue;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  // Pipeline side: drives status, consumes controls.
  modport master (
    output id_valid, id_regWrite, id_jumpMem, id_useRs1, id_useRs2,
           id_rs1, id_rs2, id_rd, ex_redirect, wb_redirect, wb_regWrite, wb_rd,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, issue, state, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_valid, id_regWrite, id_jumpMem, id_useRs1, id_useRs2,
           id_rs1, id_rs2, id_rd, ex_redirect, wb_redirect, wb_regWrite, wb_rd,
    output pc_write, ifid_write, ifid_flush, idex_bubble, issue, state, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: per-register pending-write scoreboard, stall on
// RAW hazards, flush on redirects, and a wait state behind jumpMem until WB.
module pipeline_hazard_controller (
  input  logic                          clock,
  input  logic                          reset_n,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, JWAIT = 2'd2, FLUSH = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [63:0][1:0]  cnt_q, cnt_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;

  logic hazard;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, issue;

  // No bypass: hazard looks only at registered counters, so a WB write clears
  // the pending count for ID starting the following cycle.
  assign hazard = (hz.id_useRs1 && (cnt_q[hz.id_rs1] != 2'd0)) ||
                  (hz.id_useRs2 && (cnt_q[hz.id_rs2] != 2'd0));

  // Next state and control outputs; priority wb_redirect > ex_redirect > hazard > issue.
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    issue       = 1'b0;
    case (state_q)
      RUN, STALL: begin
        if (hz.wb_redirect || hz.ex_redirect) begin
          ifid_flush = 1'b1;
          state_d    = FLUSH;
        end else if (hz.id_valid && hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          state_d    = STALL;
        end else begin
          issue       = hz.id_valid;
          idex_bubble = ~hz.id_valid;
          state_d     = (hz.id_valid && hz.id_jumpMem) ? JWAIT : RUN;
        end
      end
      JWAIT: begin
        // Front end frozen until the jumpMem resolves in WB; EX redirects are stale here.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        if (hz.wb_redirect) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          state_d    = FLUSH;
        end else if (hz.wb_regWrite) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (hz.wb_redirect) begin
          ifid_flush = 1'b1;
          state_d    = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Outputs follow reset immediately, not at the next edge.
    if (!reset_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      issue       = 1'b0;
    end
  end

  // Scoreboard update: inc on issued writer, dec on WB write, cancel when both hit one reg.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 64; i++) begin
      logic inc, dec;
      inc = issue && hz.id_regWrite && (hz.id_rd == 6'(i));
      dec = hz.wb_regWrite && (hz.wb_rd == 6'(i));
      if (inc && !dec && (cnt_q[i] != 2'd3))
        cnt_d[i] = cnt_q[i] + 2'd1;
      else if (dec && !inc && (cnt_q[i] != 2'd0))
        cnt_d[i] = cnt_q[i] - 2'd1;
    end
  end

  // Saturating count of cycles a valid ID instruction failed to advance.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (hz.id_valid && !issue && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.issue        = issue;
  assign hz.state        = state_q;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; expectations go into a queue,
// a negedge monitor pops and compares one entry per cycle.
module tb_pipeline_hazard_controller;

  logic clock, reset_n;
  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller dut (.clock(clock), .reset_n(reset_n), .hz(hz));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, issue}
  localparam logic [4:0] O_ISS  = 5'b11001;
  localparam logic [4:0] O_IDLE = 5'b11010;
  localparam logic [4:0] O_STL  = 5'b00010;
  localparam logic [4:0] O_RED  = 5'b11110;
  localparam logic [4:0] O_FLS  = 5'b11010;
  localparam logic [4:0] O_JW   = 5'b00010;

  typedef struct {
    string       name;
    logic [6:0]  o;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compare controls+state and stall counter against the oldest expectation.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = q.pop_front();
      act = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.issue, hz.state};
      checks++;
      if (act !== e.o) begin
        failures++;
        $display("FAIL %s ctrl/state: got %b want %b", e.name, act, e.o);
      end
      checks++;
      if (hz.stall_cycles !== e.sc) begin
        failures++;
        $display("FAIL %s stall_cycles: got %0d want %0d", e.name, hz.stall_cycles, e.sc);
      end
    end
  end

  task automatic ex(input string n, input logic [4:0] o, input logic [1:0] st, input logic [15:0] sc);
    exp_t e;
    e.name = n; e.o = {o, st}; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic idle();
    hz.id_valid = 0; hz.id_regWrite = 0; hz.id_jumpMem = 0;
    hz.id_useRs1 = 0; hz.id_useRs2 = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_rd = 0;
    hz.ex_redirect = 0; hz.wb_redirect = 0; hz.wb_regWrite = 0; hz.wb_rd = 0;
  endtask

  task automatic cyc();
    @(posedge clock); #1;
    idle();
  endtask

  task automatic wr(input logic [5:0] r);
    hz.id_valid = 1; hz.id_regWrite = 1; hz.id_rd = r;
  endtask

  task automatic rd1(input logic [5:0] r);
    hz.id_valid = 1; hz.id_useRs1 = 1; hz.id_rs1 = r;
  endtask

  task automatic wb(input logic [5:0] r);
    hz.wb_regWrite = 1; hz.wb_rd = r;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    // reset state
    cyc(); reset_n = 1'b0;                     ex("rst_hold", O_IDLE, 2'd0, 16'd0);
    cyc(); reset_n = 1'b1;                     ex("rst_rel",  O_IDLE, 2'd0, 16'd0);

    // single writer r5 then reader: stall until the cycle after WB
    cyc(); wr(5);                              ex("a_wr5",    O_ISS,  2'd0, 16'd0);
    cyc(); rd1(5);                             ex("a_stl1",   O_STL,  2'd0, 16'd0);
    cyc(); rd1(5); wb(5);                      ex("a_stl2",   O_STL,  2'd1, 16'd1);
    cyc(); rd1(5);                             ex("a_iss",    O_ISS,  2'd1, 16'd2);
    cyc();                                     ex("a_idle",   O_IDLE, 2'd0, 16'd2);

    // two writers of r7: reader waits for both WB writes
    cyc(); wr(7);                              ex("b_wr7a",   O_ISS,  2'd0, 16'd2);
    cyc(); wr(7);                              ex("b_wr7b",   O_ISS,  2'd0, 16'd2);
    cyc(); hz.id_valid = 1; hz.id_useRs2 = 1; hz.id_rs2 = 7;
                                               ex("b_stl1",   O_STL,  2'd0, 16'd2);
    cyc(); hz.id_valid = 1; hz.id_useRs2 = 1; hz.id_rs2 = 7; wb(7);
                                               ex("b_stl2",   O_STL,  2'd1, 16'd3);
    cyc(); hz.id_valid = 1; hz.id_useRs2 = 1; hz.id_rs2 = 7;
                                               ex("b_stl3",   O_STL,  2'd1, 16'd4);
    cyc(); hz.id_valid = 1; hz.id_useRs2 = 1; hz.id_rs2 = 7; wb(7);
                                               ex("b_stl4",   O_STL,  2'd1, 16'd5);
    cyc(); hz.id_valid = 1; hz.id_useRs2 = 1; hz.id_rs2 = 7;
                                               ex("b_iss",    O_ISS,  2'd1, 16'd6);
    cyc();                                     ex("b_idle",   O_IDLE, 2'd0, 16'd6);

    // ex_redirect beats hazard; squashed writer of r10 must not count
    cyc(); wr(9);                              ex("c_wr9",    O_ISS,  2'd0, 16'd6);
    cyc(); rd1(9); hz.id_regWrite = 1; hz.id_rd = 10; hz.ex_redirect = 1;
                                               ex("c_redir",  O_RED,  2'd0, 16'd6);
    cyc();                                     ex("c_flush",  O_FLS,  2'd3, 16'd7);
    cyc(); rd1(9);                             ex("c_stl1",   O_STL,  2'd0, 16'd7);
    cyc(); rd1(9); wb(9);                      ex("c_stl2",   O_STL,  2'd1, 16'd8);
    cyc(); rd1(9);                             ex("c_iss9",   O_ISS,  2'd1, 16'd9);
    cyc(); rd1(10);                            ex("c_iss10",  O_ISS,  2'd0, 16'd9);
    cyc();                                     ex("c_idle",   O_IDLE, 2'd0, 16'd9);

    // jumpMem taken in WB two cycles later, then FLUSH re-entry on another wb_redirect
    cyc(); hz.id_valid = 1; hz.id_jumpMem = 1; ex("d_jmp",    O_ISS,  2'd0, 16'd9);
    cyc(); hz.id_valid = 1; hz.ex_redirect = 1; ex("d_jw_exr", O_JW,   2'd2, 16'd9);
    cyc(); hz.id_valid = 1; hz.wb_redirect = 1; ex("d_jw_wbr", O_RED,  2'd2, 16'd10);
    cyc(); hz.wb_redirect = 1;                 ex("d_fl_wbr", O_RED,  2'd3, 16'd11);
    cyc();                                     ex("d_flush",  O_FLS,  2'd3, 16'd11);
    cyc();                                     ex("d_run",    O_IDLE, 2'd0, 16'd11);
    // jumpMem not taken: WB write without redirect returns to RUN
    cyc(); hz.id_valid = 1; hz.id_jumpMem = 1; ex("d_jmp2",   O_ISS,  2'd0, 16'd11);
    cyc(); wb(0);                              ex("d_jw_nt",  O_JW,   2'd2, 16'd11);
    cyc();                                     ex("d_run2",   O_IDLE, 2'd0, 16'd11);

    // async reset mid-JWAIT with r3 pending
    cyc(); wr(3);                              ex("e_wr3",    O_ISS,  2'd0, 16'd11);
    cyc(); hz.id_valid = 1; hz.id_jumpMem = 1; ex("e_jmp",    O_ISS,  2'd0, 16'd11);
    cyc();                                     ex("e_jw",     O_JW,   2'd2, 16'd11);
    cyc(); reset_n = 1'b0; rd1(3);             ex("e_rst",    O_IDLE, 2'd0, 16'd0);
    cyc(); reset_n = 1'b1; rd1(3);             ex("e_iss3",   O_ISS,  2'd0, 16'd0);
    cyc();                                     ex("e_idle",   O_IDLE, 2'd0, 16'd0);

    // stall counter saturation
    cyc(); wr(20);                             ex("f_wr20",   O_ISS,  2'd0, 16'd0);
    for (int k = 1; k <= 65540; k++) begin
      cyc(); rd1(20);
      if (k == 1)
        ex("f_stl_first", O_STL, 2'd0, 16'd0);
      else if ((k >= 65535 && k <= 65537) || k == 65540)
        ex("f_stl_sat", O_STL, 2'd1, (k - 1 > 65535) ? 16'hFFFF : 16'(k - 1));
    end
    cyc(); rd1(20); wb(20);                    ex("f_wb",     O_STL,  2'd1, 16'hFFFF);
    cyc(); rd1(20);                            ex("f_iss",    O_ISS,  2'd1, 16'hFFFF);
    cyc();                                     ex("f_idle",   O_IDLE, 2'd0, 16'hFFFF);

    cyc(); cyc();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
